// File: rtl/vid_frame_track.sv
// Video frame tracker: samples horizontal/vertical timing generator outputs,
// locks onto whole frames and emits registered video-port timing and coordinates.
module vid_frame_track #(
   parameter int unsigned XW   = 16,
   parameter int unsigned YW   = 16,
   parameter bit          HPOL = 1'b0,
   parameter bit          VPOL = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ena,
   input  logic          resync,
   input  logic          h_sync,
   input  logic          h_gate,
   input  logic          h_done,
   input  logic          v_sync,
   input  logic          v_gate,
   input  logic          v_done,
   output logic          v_ena,
   output logic          hsync_o,
   output logic          vsync_o,
   output logic          csync_o,
   output logic          blank_o,
   output logic          de_o,
   output logic [XW-1:0] pix_x,
   output logic [YW-1:0] pix_y,
   output logic          sol,
   output logic          eol,
   output logic          sof,
   output logic          eof,
   output logic [7:0]    frame_cnt,
   output logic          locked
);

   localparam int unsigned CW = 8;

   typedef enum logic {SEARCH = 1'b0, ACTIVE = 1'b1} state_e;

   state_e          state_q, state_d;
   logic            hg_q, hg_d, vg_q, vg_d;
   logic            hsync_q, hsync_d, vsync_q, vsync_d, csync_q, csync_d;
   logic            blank_q, blank_d, de_q, de_d;
   logic [XW-1:0]   pix_x_q, pix_x_d;
   logic [YW-1:0]   pix_y_q, pix_y_d;
   logic            sol_q, sol_d, eol_q, eol_d, sof_q, sof_d, eof_q, eof_d;
   logic [CW-1:0]   frame_cnt_q, frame_cnt_d;

   logic h_rise, h_fall, v_rise, frame_end, is_active;

   assign h_rise    = h_gate & ~hg_q;
   assign h_fall    = ~h_gate & hg_q;
   assign v_rise    = v_gate & ~vg_q;
   assign frame_end = h_done & v_done;
   assign is_active = (state_q == ACTIVE);

   // Vertical generator advances in the same cycle as the horizontal done.
   assign v_ena = ena & h_done;

   // Lock state: resync wins over a coincident frame end.
   always_comb begin
      state_d = state_q;
      if (ena) begin
         case (state_q)
            SEARCH:  if (frame_end && !resync) state_d = ACTIVE;
            ACTIVE:  if (resync) state_d = SEARCH;
            default: state_d = SEARCH;
         endcase
      end
   end

   always_comb begin
      hg_d        = hg_q;
      vg_d        = vg_q;
      hsync_d     = hsync_q;
      vsync_d     = vsync_q;
      csync_d     = csync_q;
      blank_d     = blank_q;
      de_d        = de_q;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      frame_cnt_d = frame_cnt_q;
      sol_d       = 1'b0;
      eol_d       = 1'b0;
      sof_d       = 1'b0;
      eof_d       = 1'b0;
      if (ena) begin
         hg_d    = h_gate;
         vg_d    = v_gate;
         hsync_d = h_sync ^ HPOL;
         vsync_d = v_sync ^ VPOL;
         csync_d = (h_sync | v_sync) ^ HPOL;
         de_d    = h_gate & v_gate & is_active;
         blank_d = ~(h_gate & v_gate & is_active);
         // Coordinates track inputs regardless of lock; counters saturate.
         if (h_rise)
            pix_x_d = '0;
         else if (h_gate && (pix_x_q != {XW{1'b1}}))
            pix_x_d = pix_x_q + XW'(1);
         if (v_rise)
            pix_y_d = '0;
         else if (h_fall && vg_q && (pix_y_q != {YW{1'b1}}))
            pix_y_d = pix_y_q + YW'(1);
         sol_d = is_active & h_rise & v_gate;
         eol_d = is_active & h_fall & vg_q;
         sof_d = is_active & v_rise;
         eof_d = is_active & frame_end & ~resync;
         if (eof_d)
            frame_cnt_d = frame_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= SEARCH;
         hg_q        <= 1'b0;
         vg_q        <= 1'b0;
         hsync_q     <= HPOL;
         vsync_q     <= VPOL;
         csync_q     <= HPOL;
         blank_q     <= 1'b1;
         de_q        <= 1'b0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         sol_q       <= 1'b0;
         eol_q       <= 1'b0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         hg_q        <= hg_d;
         vg_q        <= vg_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         csync_q     <= csync_d;
         blank_q     <= blank_d;
         de_q        <= de_d;
         pix_x_q     <= pix_x_d;
         pix_y_q     <= pix_y_d;
         sol_q       <= sol_d;
         eol_q       <= eol_d;
         sof_q       <= sof_d;
         eof_q       <= eof_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign hsync_o   = hsync_q;
   assign vsync_o   = vsync_q;
   assign csync_o   = csync_q;
   assign blank_o   = blank_q;
   assign de_o      = de_q;
   assign pix_x     = pix_x_q;
   assign pix_y     = pix_y_q;
   assign sol       = sol_q;
   assign eol       = eol_q;
   assign sof       = sof_q;
   assign eof       = eof_q;
   assign frame_cnt = frame_cnt_q;
   assign locked    = is_active;

endmodule
